cordic: RTL and testbench

CORDIC -- requirements
Module: cordic

---
 rtl/cordic_pkg.sv | 56 +++++
 rtl/cordic_stage.sv | 51 +++++
 rtl/cordic.sv | 161 ++++++++++++++++
 tb/tb_cordic.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC vectoring pipeline.
// Latency: none (types, constants and a constant table only).
// Backpressure: not applicable.
// Holds widths (Q1.16 input, Q3.20 datapath), PI, the 1/K gain constant and the atan table.
package cordic_pkg;

    localparam int IN_W    = 18;
    localparam int IN_FRAC = 16;
    localparam int DW      = 24;
    localparam int FRAC    = 20;

    localparam logic signed [DW-1:0] PI    = 24'sh3243F7;
    // 1/K for the full rotation set, Q0.20 rounded (0.6072529350 * 2^20).
    localparam logic [FRAC-1:0]      INV_K = 20'h9B74F;

    // One pipeline slot: valid bit, exact-zero input flag and the x/y/z state.
    typedef struct packed {
        logic                 vld;
        logic                 zero;
        logic signed [DW-1:0] x;
        logic signed [DW-1:0] y;
        logic signed [DW-1:0] z;
    } cordic_dat_t;

    // atan(2^-idx) in Q3.20 radians, rounded to nearest. Beyond idx 20 the
    // angle is below half an LSB and rounds to zero.
    function automatic logic signed [DW-1:0] atan_lut(input int idx);
        logic signed [DW-1:0] a;
        case (idx)
            0:       a = 24'sd823550;
            1:       a = 24'sd486170;
            2:       a = 24'sd256879;
            3:       a = 24'sd130396;
            4:       a = 24'sd65451;
            5:       a = 24'sd32757;
            6:       a = 24'sd16383;
            7:       a = 24'sd8192;
            8:       a = 24'sd4096;
            9:       a = 24'sd2048;
            10:      a = 24'sd1024;
            11:      a = 24'sd512;
            12:      a = 24'sd256;
            13:      a = 24'sd128;
            14:      a = 24'sd64;
            15:      a = 24'sd32;
            16:      a = 24'sd16;
            17:      a = 24'sd8;
            18:      a = 24'sd4;
            19:      a = 24'sd2;
            20:      a = 24'sd1;
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC vectoring micro-rotation with shift index SHIFT.
// Latency: 1 cycle.
// Backpressure: none; advances every cycle, valid bit and zero flag ride along.
// Ports: clk, rst_n (async active-low), in_dat (slot from previous stage), out_dat (registered slot).
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  cordic_dat_t in_dat,
    output cordic_dat_t out_dat
);

    localparam logic signed [DW-1:0] ATAN = atan_lut(SHIFT);

    logic signed [DW-1:0] x_cur;
    logic signed [DW-1:0] y_cur;
    logic signed [DW-1:0] x_sh;
    logic signed [DW-1:0] y_sh;
    cordic_dat_t          nxt_dat;

    assign x_cur = in_dat.x;
    assign y_cur = in_dat.y;
    assign x_sh  = x_cur >>> SHIFT;
    assign y_sh  = y_cur >>> SHIFT;

    // Rotate toward y = 0: clockwise when y is non-negative, else counter-clockwise.
    always_comb begin
        nxt_dat = in_dat;
        if (!y_cur[DW-1]) begin
            nxt_dat.x = x_cur + y_sh;
            nxt_dat.y = y_cur - x_sh;
            nxt_dat.z = in_dat.z + ATAN;
        end else begin
            nxt_dat.x = x_cur - y_sh;
            nxt_dat.y = y_cur + x_sh;
            nxt_dat.z = in_dat.z - ATAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dat <= '0;
        end else begin
            out_dat <= nxt_dat;
        end
    end

endmodule

// File: rtl/cordic.sv
// CORDIC vectoring pipeline: (x_in, y_in) -> magnitude x_out and phase_out = atan2(y, x).
// Latency: N_ITER+3 cycles from nd to rdy, N_ITER+4 when CORDIC_GAIN_COMP_EN is defined.
// Backpressure: none; one sample per cycle, rdy pulses in input order.
// Ports: clk, rst_n (async active-low); x_in/y_in signed Q1.16, nd qualifies a new sample;
//        x_out Q3.20 magnitude (carries the CORDIC gain unless CORDIC_GAIN_COMP_EN is defined),
//        phase_out Q3.20 radians in [-pi, +pi]; rdy is a one-cycle strobe for x_out/phase_out.
// N_ITER is meaningful for 16..22 (the atan table runs out of resolution beyond that).
module cordic
    import cordic_pkg::*;
#(
    parameter int N_ITER = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] x_in,
    input  logic [IN_W-1:0] y_in,
    input  logic            nd,
    output logic [DW-1:0]   x_out,
    output logic [DW-1:0]   phase_out,
    output logic            rdy
);

    localparam int EXT_W = DW - IN_W - (FRAC - IN_FRAC);

    // Input register: data only loads with nd, valid follows nd every cycle.
    logic            in_vld;
    logic [IN_W-1:0] in_x;
    logic [IN_W-1:0] in_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vld <= 1'b0;
            in_x   <= '0;
            in_y   <= '0;
        end else begin
            in_vld <= nd;
            if (nd) begin
                in_x <= x_in;
                in_y <= y_in;
            end
        end
    end

    // Quadrant fold: move the vector into the right half-plane so the
    // micro-rotations (reach about +/-1.74 rad) can always null y.
    logic signed [DW-1:0] x_ext;
    logic signed [DW-1:0] y_ext;
    cordic_dat_t          fold_nxt;
    cordic_dat_t          pipe [0:N_ITER];

    assign x_ext = {{EXT_W{in_x[IN_W-1]}}, in_x, {(FRAC-IN_FRAC){1'b0}}};
    assign y_ext = {{EXT_W{in_y[IN_W-1]}}, in_y, {(FRAC-IN_FRAC){1'b0}}};

    always_comb begin
        fold_nxt      = '0;
        fold_nxt.vld  = in_vld;
        fold_nxt.zero = (in_x == '0) && (in_y == '0);
        if (x_ext[DW-1]) begin
            fold_nxt.x = -x_ext;
            fold_nxt.y = -y_ext;
            fold_nxt.z = y_ext[DW-1] ? -PI : PI;
        end else begin
            fold_nxt.x = x_ext;
            fold_nxt.y = y_ext;
            fold_nxt.z = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe[0] <= '0;
        end else begin
            pipe[0] <= fold_nxt;
        end
    end

    for (genvar i = 0; i < N_ITER; i++) begin : g_stage
        cordic_stage #(
            .SHIFT (i)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_dat  (pipe[i]),
            .out_dat (pipe[i+1])
        );
    end

    // The fold seed already puts the angle on the correct side of the
    // negative x axis, so any overshoot past +/-pi is only accumulated
    // rounding: clamp it rather than wrap it, which keeps +pi from flipping
    // to -pi. An all-zero input has no defined angle and reports 0.
    logic signed [DW-1:0] z_last;
    logic signed [DW-1:0] phase_fin;
    logic        [DW-1:0] mag_fin;

    assign z_last  = pipe[N_ITER].z;
    assign mag_fin = pipe[N_ITER].x;

    always_comb begin
        phase_fin = z_last;
        if (pipe[N_ITER].zero) begin
            phase_fin = '0;
        end else if (z_last > PI) begin
            phase_fin = PI;
        end else if (z_last < -PI) begin
            phase_fin = -PI;
        end
    end

    logic          post_vld;
    logic [DW-1:0] post_mag;
    logic [DW-1:0] post_phase;

`ifdef CORDIC_GAIN_COMP_EN
    // Gain compensation: magnitude is non-negative here, so an unsigned
    // multiply by the Q0.20 1/K with round-half-up is sufficient.
    logic [DW+FRAC-1:0] comp_prod;
    logic               comp_vld;
    logic [DW-1:0]      comp_mag;
    logic [DW-1:0]      comp_phase;

    assign comp_prod = {{FRAC{1'b0}}, mag_fin} * {{DW{1'b0}}, INV_K}
                     + (DW+FRAC)'(1 << (FRAC-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_vld   <= 1'b0;
            comp_mag   <= '0;
            comp_phase <= '0;
        end else begin
            comp_vld   <= pipe[N_ITER].vld;
            comp_mag   <= DW'(comp_prod >> FRAC);
            comp_phase <= phase_fin;
        end
    end

    assign post_vld   = comp_vld;
    assign post_mag   = comp_mag;
    assign post_phase = comp_phase;
`else
    assign post_vld   = pipe[N_ITER].vld;
    assign post_mag   = mag_fin;
    assign post_phase = phase_fin;
`endif

    // Output register holds its value between valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out     <= '0;
            phase_out <= '0;
            rdy       <= 1'b0;
        end else begin
            rdy <= post_vld;
            if (post_vld) begin
                x_out     <= post_mag;
                phase_out <= post_phase;
            end
        end
    end

endmodule

// File: tb/tb_cordic.sv
// Self-checking bench for cordic: directed corner vectors, mid-stream reset and a random stream.
// Expected magnitude/phase come from real-valued sqrt/atan2 and the CORDIC gain product.
// Latency is counted in rising edges, the edge that samples nd being edge 1.
module tb_cordic;

    localparam int N_ITER = 20;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT     = N_ITER + 4;
    localparam bit COMP    = 1'b1;
    localparam int MAG_TOL = 8;
`else
    localparam int LAT     = N_ITER + 3;
    localparam bit COMP    = 1'b0;
    // Raw magnitude is the compensated one scaled up by K (~1.65).
    localparam int MAG_TOL = 12;
`endif
    localparam int  PH_TOL = 8;
    localparam real SCALE  = 1048576.0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] x_in;
    logic [17:0] y_in;
    logic        nd;
    logic [23:0] x_out;
    logic [23:0] phase_out;
    logic        rdy;

    cordic #(
        .N_ITER (N_ITER)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_in      (x_in),
        .y_in      (y_in),
        .nd        (nd),
        .x_out     (x_out),
        .phase_out (phase_out),
        .rdy       (rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    mag;
        int    ph;
        int    edge_n;
    } exp_t;

    exp_t expq[$];
    int   cyc      = 0;
    int   n_chk    = 0;
    int   n_err    = 0;
    int   hold_mag = 0;
    int   hold_ph  = 0;
    real  gain     = 1.0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp_v, input int tol);
        int d;
        d = obs - exp_v;
        n_chk++;
        if (d > tol || d < -tol) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (tol %0d) at cycle %0d",
                     tag, obs, exp_v, tol, cyc);
        end
    endtask

    function automatic int sx24(input logic [23:0] v);
        return int'($signed(v));
    endfunction

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    function automatic exp_t model(input string tag, input logic [17:0] xv, input logic [17:0] yv);
        exp_t e;
        int   xs;
        int   ys;
        real  xr;
        real  yr;
        xs       = $signed(xv);
        ys       = $signed(yv);
        xr       = real'(xs) / 65536.0;
        yr       = real'(ys) / 65536.0;
        e.tag    = tag;
        e.mag    = rnd($sqrt(xr * xr + yr * yr) * (COMP ? 1.0 : gain) * SCALE);
        e.ph     = (xs == 0 && ys == 0) ? 0 : rnd($atan2(yr, xr) * SCALE);
        e.edge_n = cyc + 1;
        return e;
    endfunction

    // One cycle of stimulus, applied away from the edge; the next rising edge samples it.
    task automatic drive(input logic v, input logic [17:0] xv, input logic [17:0] yv, input string tag);
        @(posedge clk);
        #2;
        nd   = v;
        x_in = xv;
        y_in = yv;
        if (v) expq.push_back(model(tag, xv, yv));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 18'($urandom), 18'($urandom), "");
    endtask

    // Random vector with magnitude >= 0.5 so phase is well conditioned.
    task automatic rand_xy(output logic [17:0] xv, output logic [17:0] yv);
        longint xs;
        longint ys;
        do begin
            xv = 18'($urandom);
            yv = 18'($urandom);
            xs = longint'($signed(xv));
            ys = longint'($signed(yv));
        end while (xs * xs + ys * ys < 64'sd1073741824);
    endtask

    // Result monitor: every rdy must match the oldest outstanding sample,
    // and outputs must hold the last result in between.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expq.delete();
                hold_mag = 0;
                hold_ph  = 0;
            end else if (rdy) begin
                if (expq.size() == 0) begin
                    check("spurious_rdy", 1, 0, 0);
                end else begin
                    e = expq.pop_front();
                    check({e.tag, "_lat"}, cyc - e.edge_n + 1, LAT, 0);
                    check({e.tag, "_mag"}, sx24(x_out), e.mag, MAG_TOL);
                    check({e.tag, "_ph"}, sx24(phase_out), e.ph, PH_TOL);
                    hold_mag = e.mag;
                    hold_ph  = e.ph;
                end
            end else begin
                check("hold_mag", sx24(x_out), hold_mag, MAG_TOL);
                check("hold_ph", sx24(phase_out), hold_ph, PH_TOL);
            end
        end
    end

    initial begin : main
        logic [17:0] rx;
        logic [17:0] ry;
        logic        v;

        for (int i = 0; i < N_ITER; i++) gain = gain * $sqrt(1.0 + $pow(2.0, -2.0 * i));

        nd    = 1'b0;
        x_in  = '0;
        y_in  = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_rdy", int'(rdy), 0, 0);
        check("rst_mag", sx24(x_out), 0, 0);
        check("rst_ph", sx24(phase_out), 0, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed vectors: axes, negative axis (+pi), diagonal, zero, corners.
        drive(1'b1, 18'h08000, 18'h00000, "pos_x");    idle(LAT + 2);
        drive(1'b1, 18'h00000, 18'h08000, "pos_y");    idle(LAT + 2);
        drive(1'b1, 18'h38000, 18'h00000, "neg_x");    idle(LAT + 2);
        drive(1'b1, 18'h08000, 18'h38000, "diag_m45"); idle(LAT + 2);
        drive(1'b1, 18'h00000, 18'h00000, "zero");     idle(LAT + 2);
        drive(1'b1, 18'h20000, 18'h20000, "min_min");  idle(LAT + 2);
        drive(1'b1, 18'h1FFFF, 18'h1FFFF, "max_max");  idle(LAT + 2);
        drive(1'b1, 18'h38000, 18'h3C000, "q3");       idle(LAT + 2);

        // Back-to-back burst cut by reset: nothing in flight may emerge.
        for (int n = 0; n < 10; n++) begin
            rand_xy(rx, ry);
            drive(1'b1, rx, ry, "flushed");
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        nd    = 1'b0;
        #1;
        check("midrst_rdy", int'(rdy), 0, 0);
        check("midrst_mag", sx24(x_out), 0, 0);
        check("midrst_ph", sx24(phase_out), 0, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(LAT + 10);
        drive(1'b1, 18'h08000, 18'h00000, "post_rst"); idle(LAT + 2);

        // Random stream with random gaps.
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(0, 3) != 0);
            rand_xy(rx, ry);
            drive(v, rx, ry, "rnd");
        end

        idle(1);
        for (int i = 0; i < LAT + 10 && expq.size() != 0; i++) @(negedge clk);
        check("drain", expq.size(), 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
